dmem_responder: RTL and testbench

//  Data-memory responder for the multicycle core's load/store path. Serves one

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one word load/store per request handshake, range-checked against DEPTH.
// Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accept edge; min WAIT_CYCLES+3 cycles/transaction.
// Backpressure: req_ready only in IDLE; the response holds in RESP until rsp_ready is seen on an edge.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready, req_write, req_addr, req_wdata : request channel from the controller
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err             : response/completion channel towards the MDR
//   busy                                                : high whenever a transaction is in flight
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 200,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0]      LP_WAIT  = 4'(WAIT_CYCLES);
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_accept;
    logic                w_access;
    logic                w_in_range;
    logic                w_mem_we;

    // Range check uses the captured address, unsigned over the full width.
    assign w_in_range = ({1'b0, r_addr} < LP_DEPTH);
    assign w_mem_we   = w_access & r_we & w_in_range;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state / strobes ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- request capture, wait counter, response data ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= req_addr;
                r_we    <= req_write;
                r_wdata <= req_wdata;
                r_cnt   <= LP_WAIT;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end

            // Response fields only change on the access edge, so they stay
            // stable through RESP and keep their last value back in IDLE.
            if (w_access) begin
                if (!w_in_range) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else if (r_we) begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end else begin
                    r_rdata <= r_mem[r_addr];
                    r_err   <= 1'b0;
                end
            end
        end
    end

    // Storage array is deliberately not reset. A reset forces IDLE, so a
    // write that has not reached its access edge can never commit.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign busy      = (r_state != S_IDLE);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk;
    logic        reset;

    // WAIT_CYCLES=2 instance
    logic        req_valid, req_write, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata, rsp_rdata;

    // WAIT_CYCLES=0 instance
    logic        z_req_valid, z_req_write, z_req_ready, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
    logic [7:0]  z_req_addr;
    logic [31:0] z_req_wdata, z_rsp_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy)
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .req_ready(z_req_ready),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
        .busy(z_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: accept, count edges until rsp_valid, optionally consume.
    // Returns #1 after the consuming edge (or #1 after rsp_valid rose if rel=0).
    task automatic txn(input bit sel, input bit wr, input logic [7:0] a, input logic [31:0] d,
                       input bit rel, output int lat, output logic [31:0] rd, output logic er);
        if (sel) begin
            z_req_valid = 1'b1; z_req_write = wr; z_req_addr = a; z_req_wdata = d;
        end else begin
            req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        end
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        req_valid   = 1'b0;
        lat = 0;
        while (!(sel ? z_rsp_valid : rsp_valid) && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = sel ? z_rsp_rdata : rsp_rdata;
        er = sel ? z_rsp_err : rsp_err;
        if (rel) begin
            if (sel) z_rsp_ready = 1'b1; else rsp_ready = 1'b1;
            @(posedge clk); #1;
            z_rsp_ready = 1'b0;
            rsp_ready   = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;

        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b0;

        // ---- reset state ----
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata",     rsp_rdata,      32'd0);
        check("rst_err",       32'(rsp_err),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        #21 reset = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // ---- T1: write then read same address, WAIT=2 ----
        txn(1'b0, 1'b1, 8'd5, 32'hDEADBEEF, 1'b1, lat, rd, er);
        check("t1_wr_lat",   32'(lat), 32'd3);
        check("t1_wr_err",   32'(er),  32'd0);
        check("t1_wr_rdata", rd,       32'd0);
        check("t1_drop_valid", 32'(rsp_valid), 32'd0);
        check("t1_idle_ready", 32'(req_ready), 32'd1);
        txn(1'b0, 1'b0, 8'd5, 32'd0, 1'b1, lat, rd, er);
        check("t1_rd_lat",   32'(lat), 32'd3);
        check("t1_rd_rdata", rd,       32'hDEADBEEF);
        check("t1_rd_err",   32'(er),  32'd0);

        // ---- T2: range boundaries ----
        txn(1'b0, 1'b1, 8'd0,   32'h11111111, 1'b1, lat, rd, er);
        txn(1'b0, 1'b1, 8'd55,  32'h55555555, 1'b1, lat, rd, er);
        txn(1'b0, 1'b1, 8'd199, 32'hC0FFEE99, 1'b1, lat, rd, er);
        check("t2_wr199_err", 32'(er), 32'd0);
        txn(1'b0, 1'b0, 8'd199, 32'd0, 1'b1, lat, rd, er);
        check("t2_rd199_err", 32'(er), 32'd0);
        check("t2_rd199",     rd,      32'hC0FFEE99);
        txn(1'b0, 1'b0, 8'd200, 32'd0, 1'b1, lat, rd, er);
        check("t2_rd200_err",   32'(er), 32'd1);
        check("t2_rd200_rdata", rd,      32'd0);
        txn(1'b0, 1'b1, 8'd255, 32'hFFFFFFFF, 1'b1, lat, rd, er);
        check("t2_wr255_err",   32'(er),  32'd1);
        check("t2_wr255_rdata", rd,       32'd0);
        check("t2_wr255_lat",   32'(lat), 32'd3);
        txn(1'b0, 1'b1, 8'd200, 32'hEEEEEEEE, 1'b1, lat, rd, er);
        check("t2_wr200_err", 32'(er), 32'd1);
        txn(1'b0, 1'b0, 8'd0, 32'd0, 1'b1, lat, rd, er);
        check("t2_rd0", rd, 32'h11111111);
        txn(1'b0, 1'b0, 8'd55, 32'd0, 1'b1, lat, rd, er);
        check("t2_rd55", rd, 32'h55555555);
        check("t2_rd55_err", 32'(er), 32'd0);
        txn(1'b0, 1'b0, 8'd199, 32'd0, 1'b1, lat, rd, er);
        check("t2_rd199_again", rd, 32'hC0FFEE99);
        txn(1'b0, 1'b0, 8'd5, 32'd0, 1'b1, lat, rd, er);
        check("t2_rd5", rd, 32'hDEADBEEF);

        // ---- T3: back-pressure in RESP ----
        txn(1'b0, 1'b0, 8'd5, 32'd0, 1'b0, lat, rd, er);
        check("t3_lat",   32'(lat), 32'd3);
        check("t3_rdata", rd,       32'hDEADBEEF);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd5; req_wdata = 32'h12345678;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("t3_hold_ctl", {29'd0, rsp_valid, req_ready, busy}, 32'b101);
            check("t3_hold_rdata", rsp_rdata, 32'hDEADBEEF);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("t3_rel_valid", 32'(rsp_valid), 32'd0);
        check("t3_rel_ready", 32'(req_ready), 32'd1);
        check("t3_rel_rdata_hold", rsp_rdata, 32'hDEADBEEF);
        txn(1'b0, 1'b0, 8'd5, 32'd0, 1'b1, lat, rd, er);
        check("t3_ignored_wr", rd, 32'hDEADBEEF);

        // ---- T4: reset during WAIT of a write ----
        txn(1'b0, 1'b1, 8'd7, 32'h00000001, 1'b1, lat, rd, er);
        txn(1'b0, 1'b0, 8'd7, 32'd0, 1'b1, lat, rd, er);
        check("t4_pre_rd7", rd, 32'h00000001);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'd7; req_wdata = 32'h00000BAD;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("t4_busy_in_wait", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check("t4_rst_valid", 32'(rsp_valid), 32'd0);
        check("t4_rst_busy",  32'(busy),      32'd0);
        check("t4_rst_rdata", rsp_rdata,      32'd0);
        check("t4_rst_err",   32'(rsp_err),   32'd0);
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        check("t4_post_ready", 32'(req_ready), 32'd1);
        txn(1'b0, 1'b0, 8'd7, 32'd0, 1'b1, lat, rd, er);
        check("t4_rd7", rd, 32'h00000001);

        // ---- T5: WAIT_CYCLES=0, back-to-back ----
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b1, 8'(i), 32'hA0 + 32'(i), 1'b1, lat, rd, er);
            check("t5_wr_lat", 32'(lat), 32'd1);
            check("t5_wr_err", 32'(er),  32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            txn(1'b1, 1'b0, 8'(i), 32'd0, 1'b1, lat, rd, er);
            check("t5_rd_lat",  32'(lat), 32'd1);
            check("t5_rd_data", rd,       32'hA0 + 32'(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
